// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg: shared widths, exception codes, unit ids and commit FSM states
package rob_commit_pkg;
    localparam int DataWidth = 32;
    localparam int RegWidth  = 5;
    localparam int ExcpWidth = 1;
    localparam int NAlu      = 3;
    localparam int CntFirst  = 0;
    localparam int CntLast   = 15;
    localparam int CntWidth  = $clog2(CntLast + 1);
    localparam int UnitWidth = $clog2(NAlu + 2);
    localparam int NoUnit    = 0;
    localparam logic [ExcpWidth-1:0] NoExcp = 1'b0;
    localparam logic [ExcpWidth-1:0] JExcp  = 1'b1;
    typedef enum logic {Run, Redirect} rob_state_e;
endpackage

// File: rtl/rob_commit_slot.sv
// rob_slot: one result slot per execution unit; capture takes priority over clear
module rob_slot
    import rob_commit_pkg::*;
#(
    parameter int CntW = CntWidth
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cap,
    input  logic                 clr,
    input  logic [CntW-1:0]      cap_cnt,
    input  logic [RegWidth-1:0]  cap_rd,
    input  logic [DataWidth-1:0] cap_data,
    input  logic [ExcpWidth-1:0] cap_excp,
    input  logic [DataWidth-1:0] cap_target,
    output logic                 valid,
    output logic [CntW-1:0]      cnt,
    output logic [RegWidth-1:0]  rd,
    output logic [DataWidth-1:0] data,
    output logic [ExcpWidth-1:0] excp,
    output logic [DataWidth-1:0] target
);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            valid  <= 1'b0;
            cnt    <= '0;
            rd     <= '0;
            data   <= '0;
            excp   <= NoExcp;
            target <= '0;
        end else if (cap) begin
            valid  <= 1'b1;
            cnt    <= cap_cnt;
            rd     <= cap_rd;
            data   <= cap_data;
            excp   <= cap_excp;
            target <= cap_target;
        end else if (clr) begin
            valid  <= 1'b0;
        end
endmodule

// File: rtl/rob_commit.sv
// rob_commit: in-order commit of ALU/MEM results by issue tag, with jump redirect
module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int nALU      = NAlu,
    parameter int CNT_FIRST = CntFirst,
    parameter int CNT_LAST  = CntLast,
    localparam int CntW     = $clog2(CNT_LAST + 1),
    localparam int UnitW    = $clog2(nALU + 2)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [nALU-1:0]           i_ALU_valid,
    input  logic [nALU*CntW-1:0]      i_ALU_cnt,
    input  logic [nALU*RegWidth-1:0]  i_ALU_rd,
    input  logic [nALU*DataWidth-1:0] i_ALU_data,
    input  logic [nALU*ExcpWidth-1:0] i_ALU_excp,
    input  logic [nALU*DataWidth-1:0] i_ALU_target,
    input  logic                      i_MEM_valid,
    input  logic [CntW-1:0]           i_MEM_cnt,
    input  logic [RegWidth-1:0]       i_MEM_rd,
    input  logic [DataWidth-1:0]      i_MEM_data,
    input  logic [ExcpWidth-1:0]      i_MEM_excp,
    output logic [RegWidth-1:0]       o_ROB_wreg,
    output logic [DataWidth-1:0]      o_ROB_wdata,
    output logic [UnitW-1:0]          o_ROB_free,
    output logic                      o_PCREG_jump,
    output logic [DataWidth-1:0]      o_PCREG_target,
    output logic                      o_err
);
    rob_state_e state, state_n;
    logic [CntW-1:0] expected;
    logic [nALU:0] cap, clr, s_valid;
    logic [CntW-1:0] c_cnt [nALU:0], s_cnt [nALU:0];
    logic [RegWidth-1:0] c_rd [nALU:0], s_rd [nALU:0];
    logic [DataWidth-1:0] c_data [nALU:0], s_data [nALU:0], c_target [nALU:0], s_target [nALU:0];
    logic [ExcpWidth-1:0] c_excp [nALU:0], s_excp [nALU:0];
    logic hit, multi, commit;
    logic [UnitW-1:0] sel;
    logic [RegWidth-1:0] sel_rd;
    logic [DataWidth-1:0] sel_data, sel_target;
    logic [ExcpWidth-1:0] sel_excp;

    for (genvar u = 0; u <= nALU; u++) begin : g_slot
        if (u < nALU) begin : g_alu
            assign cap[u]      = i_ALU_valid[u];
            assign c_cnt[u]    = i_ALU_cnt[u*CntW +: CntW];
            assign c_rd[u]     = i_ALU_rd[u*RegWidth +: RegWidth];
            assign c_data[u]   = i_ALU_data[u*DataWidth +: DataWidth];
            assign c_excp[u]   = i_ALU_excp[u*ExcpWidth +: ExcpWidth];
            assign c_target[u] = i_ALU_target[u*DataWidth +: DataWidth];
        end else begin : g_mem
            assign cap[u]      = i_MEM_valid;
            assign c_cnt[u]    = i_MEM_cnt;
            assign c_rd[u]     = i_MEM_rd;
            assign c_data[u]   = i_MEM_data;
            assign c_excp[u]   = i_MEM_excp;
            assign c_target[u] = '0;
        end
        // Redirect flushes every wrong-path slot; a same-cycle capture still wins inside the slot
        assign clr[u] = (state == Redirect) || (commit && sel == UnitW'(u));
        rob_slot #(.CntW(CntW)) u_slot (
            .clk(clk), .rst(rst), .cap(cap[u]), .clr(clr[u]),
            .cap_cnt(c_cnt[u]), .cap_rd(c_rd[u]), .cap_data(c_data[u]),
            .cap_excp(c_excp[u]), .cap_target(c_target[u]),
            .valid(s_valid[u]), .cnt(s_cnt[u]), .rd(s_rd[u]), .data(s_data[u]),
            .excp(s_excp[u]), .target(s_target[u])
        );
    end

    always_comb begin
        hit = 1'b0;
        multi = 1'b0;
        sel = '0;
        sel_rd = '0;
        sel_data = '0;
        sel_excp = NoExcp;
        sel_target = '0;
        for (int i = 0; i <= nALU; i++)
            if (s_valid[i] && s_cnt[i] == expected) begin
                multi = multi | hit;
                if (!hit) begin
                    sel = UnitW'(i);
                    sel_rd = s_rd[i];
                    sel_data = s_data[i];
                    sel_excp = s_excp[i];
                    sel_target = s_target[i];
                end
                hit = 1'b1;
            end
    end

    assign commit = (state == Run) && hit;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= Run;
        else state <= state_n;

    always_comb state_n = (commit && sel_excp == JExcp) ? Redirect : Run;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            o_ROB_wreg <= '0;
            o_ROB_wdata <= '0;
            o_ROB_free <= '0;
            o_PCREG_jump <= 1'b0;
            o_PCREG_target <= '0;
            o_err <= 1'b0;
            expected <= CntW'(CNT_FIRST + 1);
        end else begin
            o_ROB_wreg <= commit ? sel_rd : '0;
            o_ROB_free <= commit ? sel + UnitW'(1) : UnitW'(NoUnit);
            o_PCREG_jump <= state_n == Redirect;
            o_err <= o_err | (|(cap & s_valid)) | (commit && multi);
            if (commit) o_ROB_wdata <= sel_data;
            if (state_n == Redirect) o_PCREG_target <= sel_target;
            if (commit) expected <= (expected == CntW'(CNT_LAST)) ? CntW'(CNT_FIRST + 1) : expected + CntW'(1);
        end
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed-vector bench for rob_commit with hand-computed expectations
module tb_rob_commit;
    logic clk = 1'b0, rst = 1'b1;
    logic [2:0] alu_valid, alu_excp;
    logic [11:0] alu_cnt;
    logic [14:0] alu_rd;
    logic [95:0] alu_data, alu_target;
    logic mem_valid, mem_excp;
    logic [3:0] mem_cnt;
    logic [4:0] mem_rd, wreg;
    logic [31:0] mem_data, wdata, target;
    logic [2:0] free;
    logic jump, err;
    int checks = 0, errors = 0;

    rob_commit dut (
        .clk(clk), .rst(rst),
        .i_ALU_valid(alu_valid), .i_ALU_cnt(alu_cnt), .i_ALU_rd(alu_rd),
        .i_ALU_data(alu_data), .i_ALU_excp(alu_excp), .i_ALU_target(alu_target),
        .i_MEM_valid(mem_valid), .i_MEM_cnt(mem_cnt), .i_MEM_rd(mem_rd),
        .i_MEM_data(mem_data), .i_MEM_excp(mem_excp),
        .o_ROB_wreg(wreg), .o_ROB_wdata(wdata), .o_ROB_free(free),
        .o_PCREG_jump(jump), .o_PCREG_target(target), .o_err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int r, input logic [31:0] d, input int f, input int j);
        chk({tag, ".wreg"}, 32'(wreg), 32'(r));
        chk({tag, ".wdata"}, wdata, d);
        chk({tag, ".free"}, 32'(free), 32'(f));
        chk({tag, ".jump"}, 32'(jump), 32'(j));
    endtask

    task automatic idle();
        alu_valid = '0; alu_excp = '0; alu_cnt = '0; alu_rd = '0; alu_data = '0; alu_target = '0;
        mem_valid = 1'b0; mem_excp = 1'b0; mem_cnt = '0; mem_rd = '0; mem_data = '0;
    endtask

    task automatic alu(input int u, input int t, input int r, input logic [31:0] d, input logic e, input logic [31:0] tg);
        alu_valid[u] = 1'b1;
        alu_cnt[u*4 +: 4] = t[3:0];
        alu_rd[u*5 +: 5] = r[4:0];
        alu_data[u*32 +: 32] = d;
        alu_excp[u] = e;
        alu_target[u*32 +: 32] = tg;
    endtask

    task automatic mem(input int t, input int r, input logic [31:0] d);
        mem_valid = 1'b1; mem_cnt = t[3:0]; mem_rd = r[4:0]; mem_data = d; mem_excp = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous pulse placed mid-cycle; outputs are checked before any clock edge arrives
    task automatic rst_pulse(input string tag);
        idle();
        #2 rst = 1'b1;
        #1;
        chk_out(tag, 0, 32'h0, 0, 0);
        chk({tag, ".target"}, target, 32'h0);
        chk({tag, ".err"}, 32'(err), 32'h0);
        #2 rst = 1'b0;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_out("reset", 0, 32'h0, 0, 0);
        chk("reset.err", 32'(err), 32'h0);

        alu(0, 1, 5, 32'h11, 1'b0, 32'h0);
        tick();
        idle();
        alu(1, 2, 6, 32'h22, 1'b0, 32'h0);
        tick();
        chk_out("inorder1", 5, 32'h11, 1, 0);
        idle();
        tick();
        chk_out("inorder2", 6, 32'h22, 2, 0);
        tick();
        chk_out("inorder_idle", 0, 32'h22, 0, 0);
        rst_pulse("rst_sweep");

        alu(2, 2, 9, 32'h33, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        chk("ooo_wait1.wreg", 32'(wreg), 32'h0);
        tick();
        chk("ooo_wait2.wreg", 32'(wreg), 32'h0);
        mem(1, 7, 32'hAB);
        tick();
        idle();
        tick();
        chk_out("ooo_mem", 7, 32'hAB, 4, 0);
        tick();
        chk_out("ooo_alu3", 9, 32'h33, 3, 0);
        chk("ooo.err", 32'(err), 32'h0);

        rst_pulse("rst_jump");
        alu(0, 1, 1, 32'h104, 1'b1, 32'h200);
        alu(1, 2, 8, 32'h99, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        chk_out("jump", 1, 32'h104, 1, 1);
        chk("jump.target", target, 32'h200);
        tick();
        chk_out("redirect", 0, 32'h104, 0, 0);
        chk("redirect.target", target, 32'h200);
        tick();
        chk("flushed.wreg", 32'(wreg), 32'h0);
        alu(1, 2, 8, 32'h55, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        chk_out("after_jump", 8, 32'h55, 2, 0);

        rst_pulse("rst_wrap");
        for (int t = 1; t <= 15; t++) begin
            idle();
            alu((t - 1) % 3, t, t, 32'(t * 16), 1'b0, 32'h0);
            tick();
            if (t > 1) chk("wrap_seq.wreg", 32'(wreg), 32'(t - 1));
        end
        idle();
        tick();
        chk_out("wrap_last", 15, 32'hF0, 3, 0);
        alu(0, 1, 0, 32'h77, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        chk_out("wrap_x0", 0, 32'h77, 1, 0);
        chk("wrap.err", 32'(err), 32'h0);

        rst_pulse("rst_dup");
        mem(1, 10, 32'h1);
        alu(2, 2, 11, 32'h2, 1'b0, 32'h0);
        alu(0, 3, 12, 32'hC, 1'b0, 32'h0);
        alu(1, 3, 13, 32'hD, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        chk_out("dup_t1", 10, 32'h1, 4, 0);
        tick();
        chk_out("dup_t2", 11, 32'h2, 3, 0);
        chk("dup_pre.err", 32'(err), 32'h0);
        tick();
        chk_out("dup_t3", 12, 32'hC, 1, 0);
        chk("dup.err", 32'(err), 32'h1);
        tick();
        chk("dup_after.wreg", 32'(wreg), 32'h0);
        chk("dup_sticky.err", 32'(err), 32'h1);

        rst_pulse("rst_ovw");
        alu(0, 5, 1, 32'h1, 1'b0, 32'h0);
        tick();
        chk("ovw_first.err", 32'(err), 32'h0);
        tick();
        chk("ovw_second.err", 32'(err), 32'h1);
        idle();
        tick();
        chk("ovw_sticky.err", 32'(err), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
